// File: rtl/demux1to8_32_pkg.sv
// ---------------------------------------------------------------------------
// demux1to8_32_pkg
// Shared constants for the 1-to-8 write distributor and its 8:1 read-mux
// counterpart. Both blocks import this package so that channel count, select
// width and the default word width can only ever be defined in one place.
//   NCH        : number of channels / output slots
//   SELW       : width of the channel select
//   DW_DEFAULT : default data width of one word
// ---------------------------------------------------------------------------
package demux1to8_32_pkg;

  localparam int NCH        = 8;
  localparam int SELW       = 3;
  localparam int DW_DEFAULT = 32;

endpackage

// File: rtl/demux1to8_32_slot.sv
// ---------------------------------------------------------------------------
// demux1to8_32_slot
// One single-entry output slot of the distributor: a data register and a
// full flag. A load always wins over a drain, so a word arriving in the same
// cycle the consumer takes the old one simply replaces it with no bubble.
// The data register is never cleared by a drain; it keeps its last value.
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous, active-high reset (empties slot, clears data)
//   load  : write d into the slot this cycle
//   drain : consumer takes the held word this cycle
//   d     : incoming word
//   q     : slot data, registered
//   full  : slot holds a word, registered
// ---------------------------------------------------------------------------
module demux1to8_32_slot
  import demux1to8_32_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          drain,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q,
  output logic          full
);

  logic [DW-1:0] data_q, data_d;
  logic          full_q, full_d;

  // Next-state for the slot: a load captures the word and marks the slot
  // full even if it is being drained this cycle; a drain with no load only
  // drops the full flag and leaves the data untouched.
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (load) begin
      data_d = d;
      full_d = 1'b1;
    end else if (drain) begin
      full_d = 1'b0;
    end
  end

  // Slot state registers; reset discards any held word without draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign q    = data_q;
  assign full = full_q;

endmodule

// File: rtl/demux1to8_32.sv
// ---------------------------------------------------------------------------
// demux1to8_32
// Buffered 1-to-8 distributor for data words. The producer presents a word
// and a channel select; the word is steered into one of eight single-entry
// slots, each with its own valid/ready handshake toward its consumer.
// Optional feature macro: DEMUX_BCAST_EN adds the bcast port, which loads
// the word into all eight slots at once.
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous, active-high reset
//   sel       : destination channel index
//   i         : input word
//   in_valid  : producer has a word
//   in_ready  : block accepts the word this cycle (combinational)
//   o0..o7    : slot data, registered
//   o_valid   : bit k set when slot k holds a word
//   o_ready   : bit k set when consumer k takes slot k this cycle
//   xfer_cnt  : count of accepted input words, wraps
//   bcast     : broadcast request (only with DEMUX_BCAST_EN)
// ---------------------------------------------------------------------------
module demux1to8_32
  import demux1to8_32_pkg::*;
#(
  parameter int DW   = DW_DEFAULT,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SELW-1:0] sel,
  input  logic [DW-1:0]   i,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [DW-1:0]   o0,
  output logic [DW-1:0]   o1,
  output logic [DW-1:0]   o2,
  output logic [DW-1:0]   o3,
  output logic [DW-1:0]   o4,
  output logic [DW-1:0]   o5,
  output logic [DW-1:0]   o6,
  output logic [DW-1:0]   o7,
  output logic [NCH-1:0]  o_valid,
  input  logic [NCH-1:0]  o_ready,
  output logic [CNTW-1:0] xfer_cnt
`ifdef DEMUX_BCAST_EN
  ,
  input  logic            bcast
`endif
);

  logic [NCH-1:0] full;
  logic [NCH-1:0] loadVec;
  logic [NCH-1:0] drainVec;
  logic [NCH-1:0] selOneHot;
  logic [DW-1:0]  slotData [NCH];
  logic           selReady;
  logic           xfer;
  logic [CNTW-1:0] cnt_q, cnt_d;

  // A channel can take a new word when it is empty or when its consumer is
  // emptying it this very cycle, which is what lets a slot stream one word
  // per cycle. With broadcast, every channel must satisfy that at once.
  always_comb begin
    selReady  = ~full[sel] | o_ready[sel];
    selOneHot = {{(NCH-1){1'b0}}, 1'b1} << sel;
`ifdef DEMUX_BCAST_EN
    if (bcast) begin
      in_ready = &(~full | o_ready);
    end else begin
      in_ready = selReady;
    end
`else
    in_ready = selReady;
`endif
  end

  // The load vector is only non-zero on an actual transfer; drains are
  // qualified by the slot actually holding a word.
  always_comb begin
    xfer = in_valid & in_ready;
`ifdef DEMUX_BCAST_EN
    if (!xfer) begin
      loadVec = '0;
    end else if (bcast) begin
      loadVec = '1;
    end else begin
      loadVec = selOneHot;
    end
`else
    loadVec = xfer ? selOneHot : '0;
`endif
    drainVec = full & o_ready;
  end

  // Eight identical slots, each handling its own load/drain interplay.
  for (genvar k = 0; k < NCH; k++) begin : gSlot
    demux1to8_32_slot #(
      .DW(DW)
    ) uSlot (
      .clk  (clk),
      .rst  (rst),
      .load (loadVec[k]),
      .drain(drainVec[k]),
      .d    (i),
      .q    (slotData[k]),
      .full (full[k])
    );
  end

  // Transfer counter for debug; wraps naturally at the counter width.
  always_comb begin
    cnt_d = xfer ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign xfer_cnt = cnt_q;
  assign o_valid  = full;
  assign o0 = slotData[0];
  assign o1 = slotData[1];
  assign o2 = slotData[2];
  assign o3 = slotData[3];
  assign o4 = slotData[4];
  assign o5 = slotData[5];
  assign o6 = slotData[6];
  assign o7 = slotData[7];

endmodule

// File: tb/tb_demux1to8_32.sv
// ---------------------------------------------------------------------------
// tb_demux1to8_32
// Self-checking bench for demux1to8_32. A behavioural model of the eight
// slots and the transfer count is compared against the DUT every cycle, and
// directed scenarios pin the model with literal expectations. A second DUT
// instance with a 4-bit counter shares all inputs to exercise counter wrap.
// ---------------------------------------------------------------------------
module tb_demux1to8_32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  sel = '0;
  logic [31:0] i = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  o_ready = '0;
  logic        bcast = 1'b0;

  logic        in_ready, in_readyS;
  logic [31:0] o0, o1, o2, o3, o4, o5, o6, o7;
  logic [31:0] s0, s1, s2, s3, s4, s5, s6, s7;
  logic [7:0]  o_valid, o_validS;
  logic [15:0] xfer_cnt;
  logic [3:0]  xfer_cntS;
  logic [31:0] oArr [8];

  int cmpCount  = 0;
  int failCount = 0;
  bit checkEn   = 1'b0;

  // Model state: which slots hold a word, what each slot shows, how many
  // words have been accepted in total.
  logic [7:0]  mFull = '0;
  logic [31:0] mData [8];
  int          mCnt = 0;
  logic [7:0]  mLoad;
  bit          mAccept;

  always #5 clk = ~clk;

  demux1to8_32 dut (
    .clk(clk), .rst(rst), .sel(sel), .i(i), .in_valid(in_valid),
    .in_ready(in_ready),
    .o0(o0), .o1(o1), .o2(o2), .o3(o3), .o4(o4), .o5(o5), .o6(o6), .o7(o7),
    .o_valid(o_valid), .o_ready(o_ready), .xfer_cnt(xfer_cnt)
`ifdef DEMUX_BCAST_EN
    , .bcast(bcast)
`endif
  );

  demux1to8_32 #(.CNTW(4)) dutSmall (
    .clk(clk), .rst(rst), .sel(sel), .i(i), .in_valid(in_valid),
    .in_ready(in_readyS),
    .o0(s0), .o1(s1), .o2(s2), .o3(s3), .o4(s4), .o5(s5), .o6(s6), .o7(s7),
    .o_valid(o_validS), .o_ready(o_ready), .xfer_cnt(xfer_cntS)
`ifdef DEMUX_BCAST_EN
    , .bcast(bcast)
`endif
  );

  assign oArr[0] = o0;
  assign oArr[1] = o1;
  assign oArr[2] = o2;
  assign oArr[3] = o3;
  assign oArr[4] = o4;
  assign oArr[5] = o5;
  assign oArr[6] = o6;
  assign oArr[7] = o7;

  // Behavioural model: a word is taken when its destination(s) are empty or
  // being emptied now; taken words land in their slot(s), and any other slot
  // whose consumer is ready becomes empty. Reset forgets everything.
  always @(posedge clk) begin
    if (rst) begin
      mFull = '0;
      for (int k = 0; k < 8; k++) mData[k] = '0;
      mCnt = 0;
    end else begin
      mLoad = '0;
      if (bcast) begin
        mAccept = 1'b1;
        for (int k = 0; k < 8; k++)
          if (mFull[k] && !o_ready[k]) mAccept = 1'b0;
      end else begin
        mAccept = !mFull[sel] || o_ready[sel];
      end
      if (in_valid && mAccept) begin
        mCnt = mCnt + 1;
        if (bcast) mLoad = 8'hFF;
        else mLoad[sel] = 1'b1;
      end
      for (int k = 0; k < 8; k++) begin
        if (mLoad[k]) begin
          mFull[k] = 1'b1;
          mData[k] = i;
        end else if (o_ready[k]) begin
          mFull[k] = 1'b0;
        end
      end
    end
  end

  task automatic expectEq(input string name, input logic [31:0] act,
                          input logic [31:0] exp);
    cmpCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Full per-cycle comparison of every DUT output against the model.
  task automatic checkOutput();
    logic expReady;
    if (bcast) begin
      expReady = 1'b1;
      for (int k = 0; k < 8; k++)
        if (mFull[k] && !o_ready[k]) expReady = 1'b0;
    end else begin
      expReady = !mFull[sel] || o_ready[sel];
    end
    expectEq("in_ready", {31'd0, in_ready}, {31'd0, expReady});
    expectEq("in_ready_small", {31'd0, in_readyS}, {31'd0, expReady});
    expectEq("o_valid", {24'd0, o_valid}, {24'd0, mFull});
    expectEq("xfer_cnt", {16'd0, xfer_cnt}, 32'(mCnt % 65536));
    expectEq("xfer_cnt_small", {28'd0, xfer_cntS}, 32'(mCnt % 16));
    for (int k = 0; k < 8; k++)
      expectEq($sformatf("o%0d", k), oArr[k], mData[k]);
  endtask

  // Compare process: one time unit after each falling edge, once inputs for
  // the coming rising edge are in place.
  always @(negedge clk) begin
    #1;
    if (checkEn) checkOutput();
  end

  // Drive one cycle of producer/consumer inputs at the falling edge.
  task automatic applyStimulus(input logic v, input logic [2:0] s,
                               input logic [31:0] d, input logic [7:0] rdy);
    @(negedge clk);
    in_valid = v;
    sel      = s;
    i        = d;
    o_ready  = rdy;
  endtask

  initial begin
    for (int k = 0; k < 8; k++) mData[k] = '0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkEn = 1'b1;
    #2;
    expectEq("reset o_valid", {24'd0, o_valid}, 32'h0);
    expectEq("reset in_ready", {31'd0, in_ready}, 32'h1);
    expectEq("reset xfer_cnt", {16'd0, xfer_cnt}, 32'h0);
    expectEq("reset o4", o4, 32'h0);

    // Basic steer into slot 3, then backpressure on a second word.
    applyStimulus(1, 3'd3, 32'hDEADBEEF, 8'h00);
    applyStimulus(1, 3'd3, 32'hCAFEF00D, 8'h00);
    #2;
    expectEq("steer o_valid", {24'd0, o_valid}, 32'h08);
    expectEq("steer o3", o3, 32'hDEADBEEF);
    expectEq("steer stall", {31'd0, in_ready}, 32'h0);
    applyStimulus(1, 3'd3, 32'hCAFEF00D, 8'h00);
    applyStimulus(1, 3'd3, 32'hCAFEF00D, 8'h08);
    #2;
    expectEq("steer release", {31'd0, in_ready}, 32'h1);
    applyStimulus(0, 3'd0, 32'h0, 8'h00);
    #2;
    expectEq("steer o3 new", o3, 32'hCAFEF00D);
    expectEq("steer o_valid2", {24'd0, o_valid}, 32'h08);

    // Same-cycle drain and load on slot 5.
    applyStimulus(1, 3'd5, 32'h000000A1, 8'h00);
    applyStimulus(1, 3'd5, 32'h00000001, 8'h20);
    applyStimulus(0, 3'd0, 32'h0, 8'h00);
    #2;
    expectEq("swap o5", o5, 32'h1);
    expectEq("swap o_valid", {24'd0, o_valid}, 32'h28);
    expectEq("swap xfer_cnt", {16'd0, xfer_cnt}, 32'd4);

    // Drain everything; data must persist after the drain.
    applyStimulus(0, 3'd0, 32'h0, 8'hFF);
    applyStimulus(0, 3'd0, 32'h0, 8'h00);
    #2;
    expectEq("drain o_valid", {24'd0, o_valid}, 32'h0);
    expectEq("drain o3 kept", o3, 32'hCAFEF00D);

    // Streaming words 0..7 into channels 0..7, then a stalled ninth word.
    for (int k = 0; k < 8; k++) applyStimulus(1, 3'(k), 32'(k), 8'h00);
    applyStimulus(1, 3'd2, 32'h99, 8'h00);
    #2;
    expectEq("stream o_valid", {24'd0, o_valid}, 32'hFF);
    expectEq("stream stall", {31'd0, in_ready}, 32'h0);
    for (int k = 0; k < 8; k++)
      expectEq($sformatf("stream o%0d", k), oArr[k], 32'(k));
    applyStimulus(1, 3'd2, 32'h99, 8'h00);
    applyStimulus(0, 3'd0, 32'h0, 8'h00);
    #2;
    expectEq("stream xfer_cnt", {16'd0, xfer_cnt}, 32'd12);

    // Five more back-to-back words into channel 0: 17 total.
    for (int k = 0; k < 5; k++) applyStimulus(1, 3'd0, 32'h100 + 32'(k), 8'hFF);
    applyStimulus(0, 3'd0, 32'h0, 8'h00);
    #2;
    expectEq("wrap small cnt", {28'd0, xfer_cntS}, 32'd1);
    expectEq("wrap cnt", {16'd0, xfer_cnt}, 32'd17);
    expectEq("wrap o0", o0, 32'h104);

    // Mixed traffic checked by the model only.
    for (int n = 0; n < 60; n++)
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    $urandom, 8'($urandom_range(0, 255)));

    // Reset with slots 1 and 6 full.
    applyStimulus(0, 3'd0, 32'h0, 8'hFF);
    applyStimulus(1, 3'd1, 32'h11111111, 8'h00);
    applyStimulus(1, 3'd6, 32'h66666666, 8'h00);
    applyStimulus(0, 3'd0, 32'h0, 8'h00);
    #2;
    expectEq("pre-reset o_valid", {24'd0, o_valid}, 32'h42);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    expectEq("mid reset o_valid", {24'd0, o_valid}, 32'h0);
    expectEq("mid reset xfer_cnt", {16'd0, xfer_cnt}, 32'h0);
    expectEq("mid reset o6", o6, 32'h0);

`ifdef DEMUX_BCAST_EN
    // Broadcast into empty slots, then blocked by one full slot.
    @(negedge clk);
    bcast = 1'b1;
    in_valid = 1'b1;
    i = 32'hA5A5A5A5;
    o_ready = 8'h00;
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    expectEq("bcast o_valid", {24'd0, o_valid}, 32'hFF);
    expectEq("bcast o0", o0, 32'hA5A5A5A5);
    expectEq("bcast o7", o7, 32'hA5A5A5A5);
    @(negedge clk);
    o_ready = 8'hFB;
    @(negedge clk);
    o_ready = 8'h00;
    in_valid = 1'b1;
    i = 32'h5A5A5A5A;
    #2;
    expectEq("bcast blocked", {31'd0, in_ready}, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    bcast = 1'b0;
`endif

    applyStimulus(0, 3'd0, 32'h0, 8'h00);
    applyStimulus(0, 3'd0, 32'h0, 8'h00);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
    $finish;
  end

endmodule
